// File: rtl/sinc_filter_matrix_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sinc_filter_matrix_gen_if
// Brief    : Coefficient matrix and completion flag of the sinc generator.
// Revision : 1.0 - initial release
// ============================================================================
interface sinc_filter_matrix_gen_if #(
    parameter int FILTERS = 40,
    parameter int TAPS    = 12
);
    real  M [FILTERS][TAPS];
    logic done;

    modport master (output M, output done);
    modport slave  (input  M, input  done);
endinterface
`default_nettype wire

// File: rtl/sinc_filter_matrix_gen.sv
`default_nettype none
// ============================================================================
// Module   : sinc_filter_matrix_gen
// Brief    : Sequential fractional-delay sinc matrix builder, one element per
//            clock in row-major order. Optional Hann taper: SINC_WINDOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sinc_filter_matrix_gen #(
    parameter int FILTERS = 40,
    parameter int TAPS    = 12,
    parameter int SPAN    = TAPS
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    sinc_filter_matrix_gen_if.master    mif
);
    localparam int  c_FW   = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int  c_TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam real c_PI   = 3.14159265358979323846;
    localparam real c_HALF = real'(TAPS / 2);

    typedef enum logic [0:0] {
        S_GEN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [c_FW-1:0]   f_q, f_d;
    logic [c_TW-1:0]   t_q, t_d;
    logic              done_q;
    logic              wr_en;
    real               coef;

    function automatic real sinc_coef(input int f, input int t);
        real mu;
        real x;
        real c;
        mu = real'(f) / real'(FILTERS);
        x  = (real'(t) - real'(TAPS / 2 - 1) - mu) * real'(SPAN) / real'(TAPS);
        // Exact unity at the zero crossing avoids 0/0.
        if (x == 0.0)
            c = 1.0;
        else
            c = $sin(c_PI * x) / (c_PI * x);
`ifdef SINC_WINDOW_EN
        if (x < c_HALF && x > -c_HALF)
            c = c * (0.5 + 0.5 * $cos(c_PI * x / c_HALF));
        else
            c = 0.0;
`endif
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        t_d     = t_q;
        wr_en   = 1'b0;
        case (state_q)
            S_GEN: begin
                wr_en = 1'b1;
                if (t_q == c_TW'(TAPS - 1)) begin
                    t_d = '0;
                    if (f_q == c_FW'(FILTERS - 1))
                        state_d = S_DONE;
                    else
                        f_d = f_q + 1'b1;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_comb begin
        coef = sinc_coef(int'(f_q), int'(t_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_GEN;
            f_q     <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
            for (int f = 0; f < FILTERS; f++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mif.M[f][t] <= 0.0;
                end
            end
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            t_q     <= t_d;
            done_q  <= (state_d == S_DONE);
            if (wr_en)
                mif.M[f_q][t_q] <= coef;
        end
    end

    assign mif.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sinc_filter_matrix_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sinc_filter_matrix_gen
// Brief    : Directed self-checking bench for the default and a 1x4 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sinc_filter_matrix_gen;
    localparam real c_PI  = 3.14159265358979323846;
    localparam real c_TOL = 1e-9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sinc_filter_matrix_gen_if #(.FILTERS(40), .TAPS(12)) bus ();
    sinc_filter_matrix_gen_if #(.FILTERS(1),  .TAPS(4))  bus2 ();

    sinc_filter_matrix_gen #(.FILTERS(40), .TAPS(12), .SPAN(12)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (bus)
    );

    sinc_filter_matrix_gen #(.FILTERS(1), .TAPS(4), .SPAN(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .mif   (bus2)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp);
        logic close;
        close = ((obs - exp) < c_TOL) && ((exp - obs) < c_TOL);
        n_cmp++;
        assert (close === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed %0.9f expected %0.9f", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        int nz;
        nz = 0;
        for (int f = 0; f < 40; f++)
            for (int t = 0; t < 12; t++)
                if (bus.M[f][t] != 0.0) nz++;
        n_cmp++;
        assert (nz === 0) else begin
            n_err++;
            $error("FAIL %s: observed %0d nonzero elements expected 0", tag, nz);
        end
    endtask

    task automatic chk_row0_impulse(input string tag);
        for (int t = 0; t < 12; t++)
            chk_real($sformatf("%s_M0_%0d", tag, t), bus.M[0][t], (t == 5) ? 1.0 : 0.0);
    endtask

    real two_over_pi;
    real quarter_val;
    real exp_half;

    initial begin
        two_over_pi = 2.0 / c_PI;
        quarter_val = 2.0 * $sqrt(2.0) / c_PI;
`ifdef SINC_WINDOW_EN
        exp_half    = two_over_pi * (0.5 + 0.5 * $cos(c_PI / 12.0));
`else
        exp_half    = two_over_pi;
`endif

        // Reset held for two clocks
        reset = 1'b1;
        tick(2);
        chk_all_zero("reset_zero");
        chk_bit("reset_done", bus.done, 1'b0);

        reset = 1'b0;
        tick(3);
        chk_bit("small_done_e3", bus2.done, 1'b0);
        tick(1);
        chk_bit("small_done_e4", bus2.done, 1'b1);
        chk_real("small_M0", bus2.M[0][0], 0.0);
        chk_real("small_M1", bus2.M[0][1], 1.0);
        chk_real("small_M2", bus2.M[0][2], 0.0);
        chk_real("small_M3", bus2.M[0][3], 0.0);

        // Edge 5 written so far: (0,5) still unwritten
        tick(1);
        chk_real("unwritten_M0_5", bus.M[0][5], 0.0);
        tick(1);
        chk_real("written_M0_5", bus.M[0][5], 1.0);

        tick(473);
        chk_bit("done_e479", bus.done, 1'b0);
        chk_real("unwritten_last", bus.M[39][11], 0.0);
        tick(1);
        chk_bit("done_e480", bus.done, 1'b1);
        chk_row0_impulse("gen1");
        chk_real("M20_5", bus.M[20][5], exp_half);
        chk_real("M20_6", bus.M[20][6], exp_half);
`ifndef SINC_WINDOW_EN
        chk_real("M10_5", bus.M[10][5], quarter_val);
`endif

        // Idle after done
        tick(20);
        chk_bit("done_hold", bus.done, 1'b1);
        chk_bit("small_done_hold", bus2.done, 1'b1);
        chk_real("M20_5_hold", bus.M[20][5], exp_half);

        // Reset after done clears everything
        reset = 1'b1;
        tick(1);
        chk_all_zero("post_done_reset_zero");
        chk_bit("post_done_reset_done", bus.done, 1'b0);
        reset = 1'b0;

        // Abort at clock 100 of generation
        tick(100);
        chk_real("regen_M0_5", bus.M[0][5], 1.0);
        chk_bit("regen_done_e100", bus.done, 1'b0);
        reset = 1'b1;
        tick(1);
        chk_all_zero("abort_zero");
        chk_bit("abort_done", bus.done, 1'b0);
        reset = 1'b0;
        tick(479);
        chk_bit("abort_done_e479", bus.done, 1'b0);
        tick(1);
        chk_bit("abort_done_e480", bus.done, 1'b1);
        chk_row0_impulse("gen2");
        chk_real("M20_6_regen", bus.M[20][6], exp_half);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sinc_filter_matrix_gen.md
SINC_FILTER_MATRIX_GEN -- requirements
Module: sinc_filter_matrix

Interface
REQ-001 Parameter FILTERS, default 40: number of fractional-delay rows (polyphase branches), 1..256.
REQ-002 Parameter TAPS, default 12: number of coefficients per row, even, 2..64.
REQ-003 Parameter SPAN, default TAPS: sinc argument span in samples across the row; the argument scale factor is SPAN/TAPS (1.0 at default).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 M  output  real[FILTERS][TAPS]  coefficient matrix, row f = delay branch, column t = tap.
REQ-007 done  output  1  high when every element of M holds its final value.

Function
REQ-008 Fractional delay for row f: mu = f/FILTERS, giving 0 <= mu < 1.
REQ-009 Sinc argument: x = (t - (TAPS/2 - 1) - mu) * SPAN/TAPS, evaluated in real arithmetic.
REQ-010 Coefficient: M[f][t] = sin(pi*x)/(pi*x) for x != 0; M[f][t] = 1.0 exactly when x == 0.
REQ-011 Generation is sequential: one element is written per clock, in row-major order, f outer and t inner, starting at (0,0).
REQ-012 The first element is written on the first rising edge with reset low; the last element, (FILTERS-1,TAPS-1), is written FILTERS*TAPS edges after reset release.
REQ-013 done rises on the same edge that writes the last element and then stays high.
REQ-014 Elements not yet written hold 0.0; written elements never change until the next reset.
REQ-015 After done the generator is idle; the indices do not wrap and M is not rewritten.
REQ-016 The t index wraps from TAPS-1 to 0 while incrementing f.
REQ-017 With FILTERS=1 only mu=0 is generated; the row then holds integer-sample sinc values.

Reset
REQ-018 While reset is high at a rising edge, all M elements become 0.0, done becomes 0, and both indices become 0.
REQ-019 Reset asserted mid-generation aborts the sequence; generation restarts from (0,0) after release, and completes FILTERS*TAPS edges later.
REQ-020 Reset asserted after done clears M and done, then regenerates the full matrix.

Configuration
REQ-021 Macro SINC_WINDOW_EN, when defined, multiplies each coefficient by a Hann taper w = 0.5 + 0.5*cos(pi*x/(TAPS/2)) for |x| < TAPS/2, and by w = 0 otherwise.
REQ-022 Without SINC_WINDOW_EN, coefficients are the pure sinc of REQ-010; timing, ordering and the done behaviour are identical in both builds.

Verification (defaults FILTERS=40, TAPS=12, SPAN=12; tolerance 1e-9)
REQ-023 Reset high for 2 clocks -> all 480 elements read 0.0, done=0.
REQ-024 Release reset, run 480 clocks -> done=1 on edge 480 (not 479); M[0][5]=1.0; M[0][0..4] and M[0][6..11] are 0.0.
REQ-025 After done, without window -> M[20][5]=0.636620 and M[20][6]=0.636620 (2/pi); M[10][5]=sin(pi/4)/(pi/4)=0.900316.
REQ-026 Same check with SINC_WINDOW_EN defined -> M[0][5]=1.0; M[20][5]=M[20][6]=0.636620*0.982963=0.625774.
REQ-027 Assert reset at clock 100 of generation for 1 clock -> M all 0.0, done=0; done rises exactly 480 clocks after release.
REQ-028 Parameter override FILTERS=1, TAPS=4, SPAN=4 -> done after 4 clocks; M[0] = {0.0, 1.0, 0.0, 0.0}.
